rv_timer_intr_gateway: RTL and testbench
========================================

Name: rv_timer_intr_gateway

Overview:
Interrupt gateway and target arbiter that consumes rv_timer's expiry interrupts (and other peripheral interrupt lines) and presents one prioritised interrupt request to the hart.
- Per source: level/edge capture, pending (IP) and in-flight (IA) tracking, and a claim/complete handshake.
- Per target: highest-priority selection against a threshold.
- Sits between peripheral intr_*_o outputs and the core's external-interrupt input. Its register block supplies the configuration inputs.

Parameters:
NumSrc, 8, number of interrupt sources; source IDs are 1..NumSrc and ID 0 means "none"
PrioW, 2, priority field width; priority 0 = never interrupts
IdW, $clog2(NumSrc+1), width of source ID fields

Ports:
clk_i  input  1  clock
rst_ni  input  1  asynchronous active-low reset
src_i  input  NumSrc  raw interrupt lines, bit k = source ID k+1
le_i  input  NumSrc  per-source mode: 1 = edge-triggered, 0 = level-triggered
ie_i  input  NumSrc  per-source enable for the target
prio_i  input  NumSrc*PrioW  per-source priority, packed, source k at [k*PrioW +: PrioW]
threshold_i  input  PrioW  target threshold
claim_i  input  1  one-cycle pulse: claim the ID currently on irq_id_o
complete_i  input  1  one-cycle pulse: complete complete_id_i
complete_id_i  input  IdW  ID being completed
ip_o  output  NumSrc  pending bits, for register readback
irq_o  output  1  interrupt request to hart
irq_id_o  output  IdW  ID of the highest-priority eligible pending source, 0 if none

Behaviour:
- Single clock domain. Reset is asynchronous and active-low. The clock and reset ports are named clk_i and rst_ni.
- Reset values: src_q, ip, ia, irq_o and irq_id_o are all 0. Because src_q resets to 0, an edge-mode source already high at reset release counts as a rising edge on the first clock.
- Set condition per source k:
  - set_k = le_i[k] ? (src_i[k] & ~src_q[k]) : src_i[k].
  - src_q is a plain register of src_i.
- IP/IA update on each clock edge:
  - If set_k & ~ia_k: ip_k <= 1 and ia_k <= 1.
  - set_k while ia_k = 1 is dropped. Edges are lost and a held level is not re-pended until completion.
  - claim_i & (irq_id_o == k+1): ip_k <= 0. Claim has priority over set in the same cycle. Since ia_k = 1 already, set cannot re-pend in that cycle anyway.
  - complete_i & (complete_id_i == k+1): ia_k <= 0.
  - A level source still high after completion re-pends on the following edge, so there is 1 cycle of IA = 0 before set re-asserts.
- Complete-ID edge cases:
  - complete_id_i = 0, or > NumSrc: ignored.
  - Completing a source whose IA = 0: no effect.
  - Claim and complete of the same ID in the same cycle: both applied (IP and IA both cleared).
- Claim edge cases:
  - claim_i while irq_id_o = 0: no effect.
  - Claim clears only the ID on irq_id_o in that cycle, even if the arbitration inputs change the same cycle.
- Arbitration (combinational):
  - Eligible_k = ip_k & ie_i[k] & (prio_k > threshold_i).
  - Winner = eligible source with the maximum priority. Ties go to the lowest ID.
- Registered outputs:
  - irq_id_o <= winner ID (0 if none eligible).
  - irq_o <= (winner exists).
  - Latency: src_i asserting (level) to irq_o high is 2 clocks: 1 to set IP, 1 to register the arbitration. Edge mode has the same 2 clocks counted from the rising-edge cycle.
- Claim to IP cleared: 1 clock. irq_o drops, or moves to the next winner, 1 clock after that.
- Config changes (ie_i, prio_i, threshold_i) affect irq_o after 1 clock. They never alter IP/IA.
- Priority/threshold bounds: priority 0 never wins. threshold_i = 2^PrioW-1 masks all sources.
- ip_o mirrors the IP register directly (no extra latency).
- Mid-operation reset clears all state immediately, including in-flight claims. No completion is required afterwards.

Decomposition:
- Shared package rv_timer_intr_pkg holds the IdW computation function and a localparam for the "none" ID (0).
- One sub-module, intr_prio_tree: parameterised combinational binary max-tree over NumSrc (valid, prio, id) triples. Tie-break is the lower ID. Outputs the winner valid/prio/id.
- Gateway IP/IA logic is a generate loop in the top. No separate cell module.

Test Plan:
- Level mode, src 3 (ID 3) high, prio 2, threshold 0, ie set → ip_o[2] = 1 after 1 clk; irq_o = 1 with irq_id_o = 3 after 2 clk. claim → ip_o[2] = 0, irq_o = 0 next clk. src held high, complete ID 3 → re-pend 1 clk later and irq_o reasserts.
- Edge mode, ID 1: two rising edges while in-flight → only one claim is seen. New edge after complete → pends again. Src at reset release high → pends on first clock.
- Tie-break and ranking: IDs 2 and 5 both prio 3 → irq_id_o = 2. Claim → irq_id_o = 5. ID 4 prio 1 stays behind until both are claimed.
- Threshold and enable masking: prio 2 source with threshold 2 → irq_o = 0; threshold lowered to 1 → irq_o = 1 one clk later. ie cleared → irq_o = 0 while ip_o stays 1.
- Illegal and edge cases:
  - complete_id 0, 9 (NumSrc 8), or a non-in-flight ID → no state change.
  - claim with irq_id_o = 0 → no change.
  - Claim and complete of ID 3 in the same cycle → IP = IA = 0.
- Reset asserted while ID 6 is in-flight and ID 7 pending → all outputs 0 immediately (async). After release, level ID 6 still high → pends without any complete.

Source files
------------

// File: rtl/rv_timer_intr_pkg.sv
// rtl/rv_timer_intr_pkg.sv - shared constants and helpers for the interrupt gateway
package rv_timer_intr_pkg;

    localparam int unsigned NoneId = 0;

    function automatic int unsigned calc_id_w(input int unsigned num_src);
        return (num_src < 1) ? 1 : $clog2(num_src + 1);
    endfunction

endpackage

// File: rtl/intr_prio_tree.sv
// rtl/intr_prio_tree.sv - combinational max-priority tree over (valid, prio, id) triples
module intr_prio_tree
    import rv_timer_intr_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned PrioW = 2,
    parameter int unsigned IdW   = calc_id_w(N)
) (
    input  logic [N-1:0]       valid_i,
    input  logic [N*PrioW-1:0] prio_i,
    input  logic [N*IdW-1:0]   id_i,
    output logic               valid_o,
    output logic [PrioW-1:0]   prio_o,
    output logic [IdW-1:0]     id_o
);

    localparam int Levels = (N > 1) ? $clog2(N) : 1;
    localparam int Leaves = 1 << Levels;

    // Heap layout: node 1 is the root, leaves occupy [Leaves, 2*Leaves).
    logic             node_v  [2*Leaves];
    logic [PrioW-1:0] node_p  [2*Leaves];
    logic [IdW-1:0]   node_id [2*Leaves];

    function automatic logic take_right(
        input logic             lv,
        input logic [PrioW-1:0] lp,
        input logic [IdW-1:0]   lid,
        input logic             rv,
        input logic [PrioW-1:0] rp,
        input logic [IdW-1:0]   rid
    );
        return rv && (!lv || (rp > lp) || ((rp == lp) && (rid < lid)));
    endfunction

    always_comb begin
        for (int n = 0; n < 2*Leaves; n++) begin
            node_v[n]  = 1'b0;
            node_p[n]  = '0;
            node_id[n] = '0;
        end
        for (int k = 0; k < int'(N); k++) begin
            node_v[Leaves+k]  = valid_i[k];
            node_p[Leaves+k]  = prio_i[k*PrioW +: PrioW];
            node_id[Leaves+k] = id_i[k*IdW +: IdW];
        end
        for (int n = Leaves - 1; n >= 1; n--) begin
            if (take_right(node_v[2*n], node_p[2*n], node_id[2*n],
                           node_v[2*n+1], node_p[2*n+1], node_id[2*n+1])) begin
                node_v[n]  = node_v[2*n+1];
                node_p[n]  = node_p[2*n+1];
                node_id[n] = node_id[2*n+1];
            end else begin
                node_v[n]  = node_v[2*n];
                node_p[n]  = node_p[2*n];
                node_id[n] = node_id[2*n];
            end
        end
    end

    assign valid_o = node_v[1];
    assign prio_o  = node_v[1] ? node_p[1] : '0;
    assign id_o    = node_v[1] ? node_id[1] : IdW'(NoneId);

endmodule

// File: rtl/rv_timer_intr_gateway.sv
// rtl/rv_timer_intr_gateway.sv - per-source interrupt gateway plus single-target arbiter
module rv_timer_intr_gateway
    import rv_timer_intr_pkg::*;
#(
    parameter int unsigned NumSrc = 8,
    parameter int unsigned PrioW  = 2,
    parameter int unsigned IdW    = calc_id_w(NumSrc)
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NumSrc-1:0]       src_i,
    input  logic [NumSrc-1:0]       le_i,
    input  logic [NumSrc-1:0]       ie_i,
    input  logic [NumSrc*PrioW-1:0] prio_i,
    input  logic [PrioW-1:0]        threshold_i,
    input  logic                    claim_i,
    input  logic                    complete_i,
    input  logic [IdW-1:0]          complete_id_i,
    output logic [NumSrc-1:0]       ip_o,
    output logic                    irq_o,
    output logic [IdW-1:0]          irq_id_o
);

    logic [NumSrc-1:0] src_q, src_d;
    logic [NumSrc-1:0] ip_q, ip_d;
    logic [NumSrc-1:0] ia_q, ia_d;
    logic              irq_q, irq_d;
    logic [IdW-1:0]    irq_id_q, irq_id_d;

    logic [NumSrc-1:0]     set;
    logic [NumSrc-1:0]     claim_hit;
    logic [NumSrc-1:0]     complete_hit;
    logic [NumSrc-1:0]     eligible;
    logic [NumSrc*IdW-1:0] src_id;

    logic             win_valid;
    logic [PrioW-1:0] win_prio;
    logic [IdW-1:0]   win_id;

    assign src_d = src_i;

    for (genvar k = 0; k < int'(NumSrc); k++) begin : g_gw
        assign set[k]          = le_i[k] ? (src_i[k] & ~src_q[k]) : src_i[k];
        // Claim targets the ID being presented this cycle, not the new arbitration result.
        assign claim_hit[k]    = claim_i && (irq_id_q == IdW'(k + 1));
        assign complete_hit[k] = complete_i && (complete_id_i == IdW'(k + 1));
        assign ip_d[k]         = ~claim_hit[k] & (ip_q[k] | (set[k] & ~ia_q[k]));
        assign ia_d[k]         = ia_q[k] ? ~complete_hit[k] : set[k];
        assign eligible[k]     = ip_q[k] & ie_i[k] & (prio_i[k*PrioW +: PrioW] > threshold_i);
        assign src_id[k*IdW +: IdW] = IdW'(k + 1);
    end

    intr_prio_tree #(
        .N     (NumSrc),
        .PrioW (PrioW),
        .IdW   (IdW)
    ) u_prio_tree (
        .valid_i (eligible),
        .prio_i  (prio_i),
        .id_i    (src_id),
        .valid_o (win_valid),
        .prio_o  (win_prio),
        .id_o    (win_id)
    );

    always_comb begin
        irq_d    = 1'b0;
        irq_id_d = IdW'(NoneId);
        // Priority 0 can never be eligible, so a valid winner always has nonzero priority.
        if (win_valid && (win_prio != '0)) begin
            irq_d    = 1'b1;
            irq_id_d = win_id;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_q    <= '0;
            ip_q     <= '0;
            ia_q     <= '0;
            irq_q    <= 1'b0;
            irq_id_q <= '0;
        end else begin
            src_q    <= src_d;
            ip_q     <= ip_d;
            ia_q     <= ia_d;
            irq_q    <= irq_d;
            irq_id_q <= irq_id_d;
        end
    end

    assign ip_o     = ip_q;
    assign irq_o    = irq_q;
    assign irq_id_o = irq_id_q;

endmodule

// File: tb/tb_rv_timer_intr_gateway.sv
// tb/tb_rv_timer_intr_gateway.sv - self-checking bench for rv_timer_intr_gateway
module tb_rv_timer_intr_gateway;

    logic        clk;
    logic        rst_n;
    logic [7:0]  src;
    logic [7:0]  le;
    logic [7:0]  ie;
    logic [15:0] prio;
    logic [1:0]  thr;
    logic        claim;
    logic        complete;
    logic [3:0]  complete_id;
    logic [7:0]  ip;
    logic        irq;
    logic [3:0]  irq_id;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    rv_timer_intr_gateway #(.NumSrc(8), .PrioW(2)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .src_i         (src),
        .le_i          (le),
        .ie_i          (ie),
        .prio_i        (prio),
        .threshold_i   (thr),
        .claim_i       (claim),
        .complete_i    (complete),
        .complete_id_i (complete_id),
        .ip_o          (ip),
        .irq_o         (irq),
        .irq_id_o      (irq_id)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: sources indexed by ID 1..8
    bit m_srcq [1:8];
    bit m_ip   [1:8];
    bit m_ia   [1:8];
    bit m_irq;
    int m_id;
    bit n_ip   [1:8];
    bit n_ia   [1:8];
    int best_id, best_p, p;
    bit set_now;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i <= 8; i++) begin
                m_srcq[i] = 0; m_ip[i] = 0; m_ia[i] = 0;
            end
            m_irq = 0;
            m_id  = 0;
        end else begin
            best_id = 0;
            best_p  = 0;
            for (int i = 1; i <= 8; i++) begin
                p = int'(prio[(i-1)*2 +: 2]);
                if (m_ip[i] && ie[i-1] && p > int'(thr) && p > best_p) begin
                    best_p  = p;
                    best_id = i;
                end
            end
            for (int i = 1; i <= 8; i++) begin
                set_now = le[i-1] ? (src[i-1] && !m_srcq[i]) : src[i-1];
                n_ip[i] = m_ip[i];
                n_ia[i] = m_ia[i];
                if (set_now && !m_ia[i]) begin
                    n_ip[i] = 1;
                    n_ia[i] = 1;
                end
                if (claim && m_id == i) n_ip[i] = 0;
                if (complete && int'(complete_id) == i && m_ia[i]) n_ia[i] = 0;
            end
            for (int i = 1; i <= 8; i++) begin
                m_ip[i]   = n_ip[i];
                m_ia[i]   = n_ia[i];
                m_srcq[i] = src[i-1];
            end
            m_irq = (best_id != 0);
            m_id  = best_id;
        end
    end

    function automatic logic [7:0] model_ip();
        logic [7:0] v;
        for (int i = 1; i <= 8; i++) v[i-1] = m_ip[i];
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && cmp_en) begin
            check("ip_o", 32'(ip), 32'(model_ip()));
            check("irq_o", 32'(irq), 32'(m_irq));
            check("irq_id_o", 32'(irq_id), 32'(m_id));
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic set_prio(input int id, input logic [1:0] v);
        prio[(id-1)*2 +: 2] = v;
    endtask

    task automatic claim_pulse();
        claim = 1;
        step(1);
        claim = 0;
    endtask

    task automatic complete_pulse(input logic [3:0] id);
        complete    = 1;
        complete_id = id;
        step(1);
        complete    = 0;
        complete_id = 0;
    endtask

    task automatic claim_complete_pulse(input logic [3:0] id);
        claim       = 1;
        complete    = 1;
        complete_id = id;
        step(1);
        claim       = 0;
        complete    = 0;
        complete_id = 0;
    endtask

    initial begin
        rst_n = 0; src = 0; le = 0; ie = 8'hFF; prio = 0; thr = 0;
        claim = 0; complete = 0; complete_id = 0;
        step(2);
        check("reset_ip", 32'(ip), 0);
        check("reset_irq", 32'(irq), 0);
        check("reset_id", 32'(irq_id), 0);
        rst_n  = 1;
        cmp_en = 1;

        // Level mode, ID 3
        set_prio(3, 2);
        src[2] = 1;
        step(1);
        check("lvl_ip_1clk", 32'(ip[2]), 1);
        check("lvl_irq_1clk", 32'(irq), 0);
        step(1);
        check("lvl_irq_2clk", 32'(irq), 1);
        check("lvl_id_2clk", 32'(irq_id), 3);
        check("model_id", 32'(m_id), 3);
        claim_pulse();
        check("lvl_claim_ip", 32'(ip[2]), 0);
        step(1);
        check("lvl_claim_irq", 32'(irq), 0);
        complete_pulse(3);
        check("lvl_ia_gap", 32'(ip[2]), 0);
        step(1);
        check("lvl_repend", 32'(ip[2]), 1);
        step(1);
        check("lvl_reassert", 32'(irq_id), 3);
        src[2] = 0;
        claim_complete_pulse(3);
        check("cc_ip", 32'(ip[2]), 0);
        src[2] = 1;
        step(1);
        check("cc_ia_cleared", 32'(ip[2]), 1);
        src[2] = 0;
        step(1);
        claim_complete_pulse(3);
        step(2);

        // Edge mode, ID 1
        le[0] = 1;
        set_prio(1, 1);
        src[0] = 1;
        step(1);
        check("edge_ip", 32'(ip[0]), 1);
        src[0] = 0; step(1);
        src[0] = 1; step(1);
        check("edge_id", 32'(irq_id), 1);
        claim_pulse();
        step(1);
        src[0] = 0; step(1);
        src[0] = 1; step(1);
        check("edge_dropped", 32'(ip[0]), 0);
        check("edge_irq_off", 32'(irq), 0);
        complete_pulse(1);
        step(1);
        check("edge_no_level", 32'(ip[0]), 0);
        src[0] = 0; step(1);
        src[0] = 1; step(1);
        check("edge_repend", 32'(ip[0]), 1);
        src[0] = 0;
        step(1);
        claim_complete_pulse(1);
        step(2);

        // Tie-break and ranking
        set_prio(2, 3); set_prio(5, 3); set_prio(4, 1);
        src[1] = 1; src[4] = 1; src[3] = 1;
        step(2);
        check("tie_low_id", 32'(irq_id), 2);
        claim_pulse();
        step(1);
        check("tie_next", 32'(irq_id), 5);
        claim_pulse();
        step(1);
        check("rank_last", 32'(irq_id), 4);
        claim_pulse();
        step(1);
        check("rank_done", 32'(irq), 0);
        src[1] = 0; src[4] = 0; src[3] = 0;
        complete_pulse(2); complete_pulse(5); complete_pulse(4);
        step(2);

        // Threshold and enable masking, ID 6
        set_prio(6, 2);
        thr = 2;
        src[5] = 1;
        step(2);
        check("thr_masked_irq", 32'(irq), 0);
        check("thr_masked_ip", 32'(ip[5]), 1);
        thr = 1;
        step(1);
        check("thr_lowered", 32'(irq_id), 6);
        ie[5] = 0;
        step(1);
        check("ie_masked_irq", 32'(irq), 0);
        check("ie_masked_ip", 32'(ip[5]), 1);
        ie[5] = 1;
        thr = 0;
        step(1);

        // Illegal completes and claim with no winner
        claim_pulse();
        complete_pulse(0); complete_pulse(9); complete_pulse(7);
        step(2);
        check("complete_ignored", 32'(ip[5]), 0);
        ie[6] = 0;
        set_prio(7, 3);
        src[6] = 1;
        step(2);
        check("none_id", 32'(irq_id), 0);
        claim_pulse();
        step(1);
        check("claim_none", 32'(ip[6]), 1);

        // Async reset with ID 6 in flight and ID 7 pending
        ie[6] = 1;
        step(1);
        check("pre_reset_id", 32'(irq_id), 7);
        le[0]  = 1;
        src[0] = 1;
        rst_n  = 0;
        #1;
        check("async_ip", 32'(ip), 0);
        check("async_irq", 32'(irq), 0);
        check("async_id", 32'(irq_id), 0);
        step(1);
        rst_n = 1;
        step(1);
        check("post_reset_lvl", 32'(ip[5]), 1);
        check("post_reset_edge", 32'(ip[0]), 1);
        src = 0;
        for (int i = 1; i <= 8; i++) begin
            complete_pulse(4'(i));
        end
        step(2);

        // Randomized traffic
        for (int c = 0; c < 3000; c++) begin
            src = 8'($urandom);
            if ($urandom_range(0, 49) == 0) le = 8'($urandom);
            if ($urandom_range(0, 19) == 0) ie = 8'($urandom);
            if ($urandom_range(0, 19) == 0) prio = 16'($urandom);
            if ($urandom_range(0, 29) == 0) thr = 2'($urandom);
            claim       = ($urandom_range(0, 3) == 0);
            complete    = ($urandom_range(0, 2) == 0);
            complete_id = 4'($urandom_range(0, 10));
            if (c == 1500) begin
                rst_n = 0;
                #1;
                check("rand_async_irq", 32'(irq), 0);
                check("rand_async_ip", 32'(ip), 0);
                step(2);
                rst_n = 1;
            end
            step(1);
        end
        claim = 0;
        complete = 0;
        step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
